// File: rtl/svc_axi_pkg.sv
// Shared AXI encodings used by the framebuffer writer and reader.
package svc_axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/svc_pix_fb.sv
// Pixel-stream-to-framebuffer writer: each visible (x, y, rgb) pixel becomes one
// single-beat AXI write at byte address (y*h_visible + x) << awsize.
module svc_pix_fb
    import svc_axi_pkg::*;
#(
    parameter int H_WIDTH         = 12,
    parameter int V_WIDTH         = 12,
    parameter int COLOR_WIDTH     = 4,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_pix_valid,
    input  logic [COLOR_WIDTH-1:0]      s_pix_red,
    input  logic [COLOR_WIDTH-1:0]      s_pix_grn,
    input  logic [COLOR_WIDTH-1:0]      s_pix_blu,
    input  logic [H_WIDTH-1:0]          s_pix_x,
    input  logic [V_WIDTH-1:0]          s_pix_y,
    output logic                        s_pix_ready,
    input  logic [H_WIDTH-1:0]          h_visible,
    input  logic [V_WIDTH-1:0]          v_visible,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    input  logic                        m_axi_bvalid,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    output logic                        m_axi_bready,
    output logic                        idle,
    output logic                        err
);

    localparam int AWSIZE  = $clog2(AXI_DATA_WIDTH / 8);
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int IDX_W   = H_WIDTH + V_WIDTH;
    localparam int FULL_W  = IDX_W + AWSIZE + AXI_ADDR_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;

    logic             accept;
    logic             in_range;
    logic             issue;
    logic             b_dec;
    logic [IDX_W-1:0] pix_idx;
    logic [FULL_W-1:0] byte_addr;

    // Response id carries no information here: every write uses id 0.
    logic unused_bid;
    assign unused_bid = ^m_axi_bid;

    // A new pixel may enter only when both output slots can take it and the
    // outstanding-write budget has room.
    assign s_pix_ready = (!awvalid_q || m_axi_awready)
                       && (!wvalid_q || m_axi_wready)
                       && (cnt_q < CNT_MAX);
    assign accept   = s_pix_valid && s_pix_ready;
    assign in_range = (s_pix_x < h_visible) && (s_pix_y < v_visible);
    assign issue    = accept && in_range;
    assign b_dec    = m_axi_bvalid && (cnt_q != '0);

    // Linear pixel index and its byte address; upper bits beyond the bus are dropped.
    assign pix_idx   = {{H_WIDTH{1'b0}}, s_pix_y} * {{V_WIDTH{1'b0}}, h_visible}
                     + {{V_WIDTH{1'b0}}, s_pix_x};
    assign byte_addr = FULL_W'(pix_idx) << AWSIZE;

    // Next-state for both AXI slots, the outstanding counter and the sticky error.
    always_comb begin
        awvalid_d = awvalid_q && !m_axi_awready;
        wvalid_d  = wvalid_q && !m_axi_wready;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        if (issue) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = byte_addr[AXI_ADDR_WIDTH-1:0];
            wdata_d   = AXI_DATA_WIDTH'({s_pix_red, s_pix_grn, s_pix_blu});
        end
        case ({issue, b_dec})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY)) begin
            err_d = 1'b1;
        end
    end

    // Control state: cleared by reset, abandoning any in-flight writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Payload registers are qualified by their valids, so they need no reset.
    always_ff @(posedge clk) begin
        awaddr_q <= awaddr_d;
        wdata_q  <= wdata_d;
    end

    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awid    = '0;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'(AWSIZE);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_bready  = 1'b1;
    assign idle          = (cnt_q == '0) && !awvalid_q && !wvalid_q;
    assign err           = err_q;

endmodule
